// File: rtl/abro_pkg.sv
// Shared types for the ABRO stimulus driver: FSM state encoding and result codes.
package abro_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_WAIT_A  = 3'd2,
        S_PULSE_A = 3'd3,
        S_WAIT_B  = 3'd4,
        S_PULSE_B = 3'd5,
        S_WAIT_O  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // One code per completed run keeps pass/err_early/err_timeout mutually exclusive.
    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_PASS    = 2'd1;
    localparam logic [1:0] RES_EARLY   = 2'd2;
    localparam logic [1:0] RES_TIMEOUT = 2'd3;

endpackage

// File: rtl/abro_gap_counter.sv
// Loadable down-counter with zero flag; saturates at zero so a held decrement never wraps.
module abro_gap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/abro_seq_driver.sv
// ABRO detector stimulus driver: reset pulse, A/B pulses after programmable gaps,
// bounded wait for O, then a pass / early / timeout verdict with response latency.
module abro_seq_driver
    import abro_pkg::*;
#(
    parameter int GAP_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int LAT_W   = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [GAP_W-1:0] gap_a,
    input  logic [GAP_W-1:0] gap_b,
    input  logic             both_mode,
    input  logic             o_in,
    output logic             det_rst_n,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_early,
    output logic             err_timeout,
    output logic [LAT_W-1:0] latency
);

    // One counter serves both gaps and the O window, so it is as wide as the larger.
    localparam int CW = (GAP_W > LAT_W) ? GAP_W : LAT_W;
    localparam logic [CW-1:0] WIN_LOAD = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WIN_LEN  = CW'(TIMEOUT);

    state_t             state;
    state_t             next_state;
    logic [GAP_W-1:0]   gap_a_q;
    logic [GAP_W-1:0]   gap_b_q;
    logic               both_q;
    logic [1:0]         res_q;
    logic [LAT_W-1:0]   lat_q;
    logic               cnt_load;
    logic               cnt_dec;
    logic [CW-1:0]      cnt_val;
    logic [CW-1:0]      cnt;
    logic               cnt_zero;

    abro_gap_counter #(.W(CW)) u_gap_counter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_RST;
            S_RST:     next_state = (gap_a_q != '0) ? S_WAIT_A : S_PULSE_A;
            S_WAIT_A: begin
                if (o_in)          next_state = S_DONE;
                else if (cnt_zero) next_state = S_PULSE_A;
            end
            S_PULSE_A: begin
                if (both_q)              next_state = o_in ? S_DONE : S_WAIT_O;
                else if (o_in)           next_state = S_DONE;
                else if (gap_b_q != '0)  next_state = S_WAIT_B;
                else                     next_state = S_PULSE_B;
            end
            S_WAIT_B: begin
                if (o_in)          next_state = S_DONE;
                else if (cnt_zero) next_state = S_PULSE_B;
            end
            S_PULSE_B: next_state = o_in ? S_DONE : S_WAIT_O;
            S_WAIT_O:  if (o_in || cnt_zero) next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Gaps load as N-1 so the wait state lasts exactly N cycles, ending on zero.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            S_RST: begin
                cnt_load = 1'b1;
                cnt_val  = CW'(gap_a_q - GAP_W'(1));
            end
            S_PULSE_A: begin
                cnt_load = 1'b1;
                cnt_val  = both_q ? WIN_LOAD : CW'(gap_b_q - GAP_W'(1));
            end
            S_PULSE_B: begin
                cnt_load = 1'b1;
                cnt_val  = WIN_LOAD;
            end
            S_WAIT_A, S_WAIT_B, S_WAIT_O: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gap_a_q <= '0;
            gap_b_q <= '0;
            both_q  <= 1'b0;
            res_q   <= RES_NONE;
            lat_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        gap_a_q <= gap_a;
                        gap_b_q <= gap_b;
                        both_q  <= both_mode;
                        res_q   <= RES_NONE;
                        lat_q   <= '0;
                    end
                end
                S_WAIT_A, S_WAIT_B: if (o_in) res_q <= RES_EARLY;
                S_PULSE_A: if (o_in) res_q <= both_q ? RES_PASS : RES_EARLY;
                S_PULSE_B: if (o_in) res_q <= RES_PASS;
                S_WAIT_O: begin
                    // Window cycle k sees count TIMEOUT-k, so the latency is the difference.
                    if (o_in) begin
                        res_q <= RES_PASS;
                        lat_q <= LAT_W'(WIN_LEN - cnt);
                    end else if (cnt_zero) begin
                        res_q <= RES_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        det_rst_n   = (state != S_RST);
        a_out       = (state == S_PULSE_A);
        b_out       = (state == S_PULSE_B) || ((state == S_PULSE_A) && both_q);
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        pass        = (res_q == RES_PASS);
        err_early   = (res_q == RES_EARLY);
        err_timeout = (res_q == RES_TIMEOUT);
        latency     = lat_q;
    end

endmodule

// File: tb/tb_abro_seq_driver.sv
// Bench for abro_seq_driver: directed and random runs scored against a cycle-index model.
module tb_abro_seq_driver;

    localparam int GAP_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int LAT_W   = 5;
    localparam int BUDGET  = 400;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [GAP_W-1:0] gap_a = '0;
    logic [GAP_W-1:0] gap_b = '0;
    logic             both_mode = 1'b0;
    logic             o_in = 1'b0;
    logic             det_rst_n, a_out, b_out, busy, done;
    logic             pass, err_early, err_timeout;
    logic [LAT_W-1:0] latency;

    int checks = 0;
    int errors = 0;

    abro_seq_driver #(.GAP_W(GAP_W), .TIMEOUT(TIMEOUT), .LAT_W(LAT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .gap_a       (gap_a),
        .gap_b       (gap_b),
        .both_mode   (both_mode),
        .o_in        (o_in),
        .det_rst_n   (det_rst_n),
        .a_out       (a_out),
        .b_out       (b_out),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_early   (err_early),
        .err_timeout (err_timeout),
        .latency     (latency)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({det_rst_n, a_out, b_out, busy, done, pass, err_early, err_timeout, latency});
    endfunction

    // Cycle n = the clock period that begins n-1 edges after the edge sampling start.
    // o_rel is the single cycle in which o_in pulses (-1 = never).
    task automatic run_case(input string name, input int ga, input int gb, input bit both,
                            input int o_rel);
        int a_c, b_c, exp_a, exp_b, exp_done, exp_lat, exp_res;
        int rst_first, rst_cnt, a_first, a_cnt, b_first, b_cnt, done_cnt, done_first, idle_cnt;
        int res_o, lat_o;
        bit seen;

        a_c = 2 + ga;
        b_c = both ? a_c : a_c + 1 + gb;
        exp_lat = 0;
        if (o_rel >= 2 && o_rel < b_c) begin
            exp_res  = 2;
            exp_done = o_rel + 1;
            exp_a    = (a_c <= o_rel) ? a_c : 0;
            exp_b    = 0;
        end else if (o_rel >= b_c && o_rel <= b_c + TIMEOUT) begin
            exp_res  = 1;
            exp_lat  = o_rel - b_c;
            exp_done = o_rel + 1;
            exp_a    = a_c;
            exp_b    = b_c;
        end else begin
            exp_res  = 3;
            exp_done = b_c + TIMEOUT + 1;
            exp_a    = a_c;
            exp_b    = b_c;
        end

        @(negedge clk);
        gap_a     = ga[GAP_W-1:0];
        gap_b     = gb[GAP_W-1:0];
        both_mode = both;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        rst_first = 0; rst_cnt = 0; a_first = 0; a_cnt = 0; b_first = 0; b_cnt = 0;
        done_cnt = 0; done_first = 0; idle_cnt = 0; res_o = 0; lat_o = 0; seen = 1'b0;
        for (int n = 1; n <= BUDGET && !seen; n++) begin
            o_in = (n == o_rel);
            @(negedge clk);
            if (!det_rst_n) begin rst_cnt++; if (rst_first == 0) rst_first = n; end
            if (a_out) begin a_cnt++; if (a_first == 0) a_first = n; end
            if (b_out) begin b_cnt++; if (b_first == 0) b_first = n; end
            if (!busy) idle_cnt++;
            if (done) begin
                done_cnt++;
                done_first = n;
                seen = 1'b1;
                res_o = pass ? 1 : err_early ? 2 : err_timeout ? 3 : 0;
                lat_o = 32'(latency);
            end
            @(posedge clk);
            #1;
        end
        o_in = 1'b0;

        check($sformatf("%s.done_seen", name), 32'(seen), 1);
        check($sformatf("%s.done_cycle", name), done_first, exp_done);
        check($sformatf("%s.rst_cycle", name), rst_first, 1);
        check($sformatf("%s.rst_count", name), rst_cnt, 1);
        check($sformatf("%s.a_cycle", name), a_first, exp_a);
        check($sformatf("%s.a_count", name), a_cnt, (exp_a != 0) ? 1 : 0);
        check($sformatf("%s.b_cycle", name), b_first, exp_b);
        check($sformatf("%s.b_count", name), b_cnt, (exp_b != 0) ? 1 : 0);
        check($sformatf("%s.busy_gap", name), idle_cnt, 0);
        check($sformatf("%s.result", name), res_o, exp_res);
        check($sformatf("%s.latency", name), lat_o, exp_lat);
        check($sformatf("%s.flag_onehot", name), 32'($countones({pass, err_early, err_timeout})), 1);

        // One cycle after DONE: idle, and the verdict must still be held.
        @(negedge clk);
        check($sformatf("%s.idle_after", name), 32'({busy, done}), 0);
        check($sformatf("%s.hold_result", name),
              pass ? 1 : err_early ? 2 : err_timeout ? 3 : 0, exp_res);
        check($sformatf("%s.hold_latency", name), 32'(latency), exp_lat);
    endtask

    initial begin
        int ga, gb, bcyc, sel, orel;
        int rst_cnt, a_cnt, b_cnt, done_cnt;
        bit both;

        #12;
        check("reset.outputs", out_vec(), 32'h1000);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("reset.idle", out_vec(), 32'h1000);

        run_case("gap2_3_pass", 2, 3, 1'b0, 10);
        run_case("both_timeout", 0, 9, 1'b1, -1);
        run_case("early_wait_a", 5, 0, 1'b0, 4);
        run_case("zero_gaps_lat0", 0, 0, 1'b0, 3);
        run_case("gap_a_max", 255, 0, 1'b0, -1);
        run_case("win_last", 1, 1, 1'b0, 5 + TIMEOUT);
        run_case("win_past", 1, 1, 1'b0, 6 + TIMEOUT);
        run_case("early_pulse_a", 1, 2, 1'b0, 3);
        run_case("both_lat0", 3, 0, 1'b1, 5);
        run_case("rst_cycle_o_ignored", 0, 0, 1'b0, 1);

        // Second start while busy is ignored; reset in WAIT_B aborts immediately.
        @(negedge clk);
        gap_a = 8'd1; gap_b = 8'd5; both_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rst_cnt = 0; a_cnt = 0; b_cnt = 0; done_cnt = 0;
        for (int n = 1; n <= 6; n++) begin
            start = (n == 2);
            @(negedge clk);
            if (!det_rst_n) rst_cnt++;
            if (a_out) a_cnt++;
            if (b_out) b_cnt++;
            if (done) done_cnt++;
            if (n < 6) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        check("abort.busy_before", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        check("abort.outputs", out_vec(), 32'h1000);
        check("abort.rst_count", rst_cnt, 1);
        check("abort.a_count", a_cnt, 1);
        check("abort.b_count", b_cnt, 0);
        check("abort.done_count", done_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort.held", out_vec(), 32'h1000);
        @(negedge clk);
        resetn = 1'b1;
        run_case("after_abort", 2, 1, 1'b0, 7);

        for (int i = 0; i < 24; i++) begin
            ga   = $urandom_range(0, 6);
            gb   = $urandom_range(0, 6);
            both = 1'($urandom_range(0, 1));
            bcyc = both ? 2 + ga : 3 + ga + gb;
            sel  = $urandom_range(0, 3);
            orel = (sel == 0) ? -1 : $urandom_range(1, bcyc + TIMEOUT + 2);
            run_case($sformatf("rnd%0d", i), ga, gb, both, orel);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
